// File: rtl/nav_cmd_pkg.sv
// Shared types and constants for the navigation command scheduler:
// opcodes, response codes and the scheduler state encoding.
package nav_cmd_pkg;

    localparam int CMD_W = 16;

    typedef enum logic [2:0] {
        CAL   = 3'b000,
        HDNG  = 3'b001,
        MOVE  = 3'b010,
        FLUSH = 3'b111
    } opcode_e;

    localparam logic [7:0] RESP_DONE  = 8'hA5;
    localparam logic [7:0] RESP_ILL   = 8'hEE;
    localparam logic [7:0] RESP_TMO   = 8'hE0;
    localparam logic [7:0] RESP_FLUSH = 8'hC3;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_NAV,
        WAIT_CAL,
        RESP
    } state_t;

endpackage

// File: rtl/nav_cmd_fifo.sv
// DEPTH x CMD_W synchronous FIFO with wrap-bit pointers and a clear input.
// clr wins over a write but a read in the same cycle still returns the head.
module nav_cmd_fifo
    import nav_cmd_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             wr_en,
    input  logic             rd_en,
    input  logic [CMD_W-1:0] wdata,
    output logic [CMD_W-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic [CMD_W-1:0] mem_q [DEPTH];
    logic             do_wr;
    logic             do_rd;

    // Same slot with differing wrap bits means the writer lapped the reader.
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign do_wr = wr_en && !full && !clr;
    assign do_rd = rd_en && !empty;
    assign rdata = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else if (clr) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_wr) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (do_rd) rd_ptr_q <= rd_ptr_q + PTR_ONE;
        end
    end

    // NOTE: storage is deliberately not reset; the pointers alone say which entries are valid.
    always_ff @(posedge clk) begin
        if (do_wr) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/nav_cmd_sched.sv
// Buffers motion commands, issues them one at a time to navigate/calibration
// and returns a response code per command. Define NAV_CMD_TMO_EN for the watchdog.
module nav_cmd_sched
    import nav_cmd_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TMO_W = 26
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [CMD_W-1:0]  cmd,
    input  logic              cmd_vld,
    output logic              cmd_full,
    output logic              ovfl,
    output logic              busy,
    output logic              strt_cal,
    input  logic              cal_done,
    output logic              strt_hdng,
    output logic              strt_mv,
    output logic [11:0]       dsrd_hdng,
    output logic              stp_lft,
    output logic              stp_rght,
    input  logic              mv_cmplt,
    output logic              send_resp,
    output logic [7:0]        resp
);

    state_t           state_q;
    logic [2:0]       cur_op_q;
    logic             flush_pend_q;
    logic             ovfl_q;
    logic             strt_cal_q;
    logic             strt_hdng_q;
    logic             strt_mv_q;
    logic [11:0]      dsrd_hdng_q;
    logic             stp_lft_q;
    logic             stp_rght_q;
    logic             send_resp_q;
    logic [7:0]       resp_q;

    logic             flush_now;
    logic             wr_en;
    logic             rd_en;
    logic             drop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CMD_W-1:0] head;
    logic [2:0]       head_op;
    logic             rsvd_unused;
    logic             tmo_hit;

    assign flush_now   = cmd_vld && (cmd[15:13] == FLUSH);
    assign wr_en       = cmd_vld && !flush_now;
    assign drop        = wr_en && fifo_full;
    assign rd_en       = (state_q == IDLE) && !flush_pend_q && !fifo_empty;
    assign head_op     = head[15:13];
    assign rsvd_unused = head[12];

    nav_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (flush_now),
        .wr_en (wr_en),
        .rd_en (rd_en),
        .wdata (cmd),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

`ifdef NAV_CMD_TMO_EN
    localparam logic [TMO_W-1:0] TMO_ONE = TMO_W'(1);

    logic [TMO_W-1:0] wdog_q;
    logic [TMO_W-1:0] wdog_inc;

    // Fires on the edge at which the counter would reach all-ones.
    assign wdog_inc = wdog_q + TMO_ONE;
    assign tmo_hit  = &wdog_inc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdog_q <= '0;
        end else if (rd_en) begin
            wdog_q <= '0;
        end else if ((state_q == WAIT_NAV) || (state_q == WAIT_CAL)) begin
            wdog_q <= wdog_inc;
        end
    end
`else
    logic [TMO_W-1:0] wdog_unused;

    assign wdog_unused = '0;
    assign tmo_hit     = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cur_op_q     <= '0;
            flush_pend_q <= 1'b0;
            ovfl_q       <= 1'b0;
            strt_cal_q   <= 1'b0;
            strt_hdng_q  <= 1'b0;
            strt_mv_q    <= 1'b0;
            dsrd_hdng_q  <= '0;
            stp_lft_q    <= 1'b0;
            stp_rght_q   <= 1'b0;
            send_resp_q  <= 1'b0;
            resp_q       <= '0;
        end else begin
            // NOTE: non-blocking throughout, so every branch below sees pre-edge values and later writes override defaults.
            strt_cal_q  <= 1'b0;
            strt_hdng_q <= 1'b0;
            strt_mv_q   <= 1'b0;
            send_resp_q <= 1'b0;

            if (flush_now) begin
                ovfl_q       <= 1'b0;
                flush_pend_q <= 1'b1;
            end else if (drop) begin
                ovfl_q <= 1'b1;
            end

            case (state_q)
                IDLE: begin
                    if (flush_pend_q) begin
                        send_resp_q  <= 1'b1;
                        resp_q       <= RESP_FLUSH;
                        flush_pend_q <= flush_now;
                    end else if (!fifo_empty) begin
                        // Strobes are launched at the pop so they coincide with ISSUE.
                        state_q  <= ISSUE;
                        cur_op_q <= head_op;
                        case (head_op)
                            CAL:  strt_cal_q <= 1'b1;
                            HDNG: begin
                                strt_hdng_q <= 1'b1;
                                dsrd_hdng_q <= head[11:0];
                            end
                            MOVE: begin
                                strt_mv_q  <= 1'b1;
                                stp_lft_q  <= head[1];
                                stp_rght_q <= head[0];
                            end
                            default: ;
                        endcase
                    end else if (flush_now) begin
                        send_resp_q  <= 1'b1;
                        resp_q       <= RESP_FLUSH;
                        flush_pend_q <= 1'b0;
                    end
                end
                ISSUE: begin
                    case (cur_op_q)
                        CAL:        state_q <= WAIT_CAL;
                        HDNG, MOVE: state_q <= WAIT_NAV;
                        default: begin
                            resp_q      <= RESP_ILL;
                            send_resp_q <= 1'b1;
                            state_q     <= RESP;
                        end
                    endcase
                end
                WAIT_NAV, WAIT_CAL: begin
                    if (((state_q == WAIT_NAV) && mv_cmplt) ||
                        ((state_q == WAIT_CAL) && cal_done)) begin
                        resp_q      <= RESP_DONE;
                        stp_lft_q   <= 1'b0;
                        stp_rght_q  <= 1'b0;
                        send_resp_q <= 1'b1;
                        state_q     <= RESP;
                    end else if (tmo_hit) begin
                        resp_q      <= RESP_TMO;
                        stp_lft_q   <= 1'b0;
                        stp_rght_q  <= 1'b0;
                        send_resp_q <= 1'b1;
                        state_q     <= RESP;
                    end
                end
                RESP:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cmd_full  = fifo_full;
    assign ovfl      = ovfl_q;
    assign busy      = (state_q != IDLE);
    assign strt_cal  = strt_cal_q;
    assign strt_hdng = strt_hdng_q;
    assign strt_mv   = strt_mv_q;
    assign dsrd_hdng = dsrd_hdng_q;
    assign stp_lft   = stp_lft_q;
    assign stp_rght  = stp_rght_q;
    assign send_resp = send_resp_q;
    assign resp      = resp_q;

endmodule

// File: tb/tb_nav_cmd_sched.sv
// Self-checking bench for nav_cmd_sched: directed scenarios followed by random
// command bursts checked against a queue-based model of accepted commands.
module tb_nav_cmd_sched;

    localparam int DEPTH = 4;
    localparam int TMO_W = 4;
    localparam logic [7:0] R_DONE  = 8'hA5;
    localparam logic [7:0] R_ILL   = 8'hEE;
    localparam logic [7:0] R_TMO   = 8'hE0;
    localparam logic [7:0] R_FLUSH = 8'hC3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] cmd = '0;
    logic        cmd_vld = 1'b0;
    logic        cal_done = 1'b0;
    logic        mv_cmplt = 1'b0;
    logic        cmd_full, ovfl, busy, strt_cal, strt_hdng, strt_mv;
    logic [11:0] dsrd_hdng;
    logic        stp_lft, stp_rght, send_resp;
    logic [7:0]  resp;

    int tests = 0;
    int fails = 0;

    // Start-pulse monitor: counts pulses and captures what navigate would see.
    int          strt_cnt = 0;
    logic [2:0]  last_strt = '0;
    logic [11:0] last_hdng = '0;
    logic [1:0]  last_stp = '0;

    nav_cmd_sched #(.DEPTH(DEPTH), .TMO_W(TMO_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd       (cmd),
        .cmd_vld   (cmd_vld),
        .cmd_full  (cmd_full),
        .ovfl      (ovfl),
        .busy      (busy),
        .strt_cal  (strt_cal),
        .cal_done  (cal_done),
        .strt_hdng (strt_hdng),
        .strt_mv   (strt_mv),
        .dsrd_hdng (dsrd_hdng),
        .stp_lft   (stp_lft),
        .stp_rght  (stp_rght),
        .mv_cmplt  (mv_cmplt),
        .send_resp (send_resp),
        .resp      (resp)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        if (strt_cal || strt_hdng || strt_mv) begin
            strt_cnt++;
            last_strt = {strt_cal, strt_hdng, strt_mv};
            last_hdng = dsrd_hdng;
            last_stp  = {stp_lft, stp_rght};
        end
    end

    initial begin
        #2000000;
        $display("FAIL tb_time_limit: simulation did not finish, required to finish");
        $fatal(1, "time limit");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic send(input logic [15:0] w);
        cmd     = w;
        cmd_vld = 1'b1;
        tick();
        cmd_vld = 1'b0;
        cmd     = '0;
    endtask

    task automatic check_zero(input string tag);
        check(tag, {cmd_full, ovfl, busy, strt_cal, strt_hdng, strt_mv, stp_lft, stp_rght,
                    send_resp, resp, dsrd_hdng}, 32'h0);
    endtask

    function automatic logic [15:0] rand_cmd(input bit legal_only);
        logic [2:0]  op;
        logic [12:0] low;
        op  = 3'($urandom_range(0, legal_only ? 2 : 6));
        low = 13'($urandom());
        return {op, low};
    endfunction

    logic [15:0] q[$];
    logic [15:0] w;
    logic [2:0]  op;
    logic [11:0] m_hdng;
    int          len;
    int          used;
    int          waited;
    int          cnt0;

    initial begin
        // Reset state
        repeat (3) tick();
        check_zero("reset_outputs");
        rst_n = 1'b1;
        tick();
        check_zero("after_reset_release");

        // HDNG 0x23FF, completion 20 cycles after strt_hdng
        send(16'h23FF);
        check("hdng_c1_no_strt", strt_hdng, 1'b0);
        tick();
        check("hdng_c2_strt", {strt_cal, strt_hdng, strt_mv}, 3'b010);
        check("hdng_c2_heading", dsrd_hdng, 12'h3FF);
        check("hdng_c2_busy", busy, 1'b1);
        tick();
        check("hdng_c3_strt_gone", strt_hdng, 1'b0);
        repeat (19) tick();
        mv_cmplt = 1'b1;
        check("hdng_no_early_resp", send_resp, 1'b0);
        tick();
        mv_cmplt = 1'b0;
        check("hdng_resp_strobe", send_resp, 1'b1);
        check("hdng_resp_code", resp, R_DONE);
        tick();
        check("hdng_resp_one_cycle", send_resp, 1'b0);
        check("hdng_resp_held", resp, R_DONE);
        check("hdng_idle", busy, 1'b0);

        // MOVE 0x4002: stop-left held for the whole move
        send(16'h4002);
        tick();
        check("move_strt", {strt_cal, strt_hdng, strt_mv}, 3'b001);
        check("move_stp", {stp_lft, stp_rght}, 2'b10);
        check("move_heading_kept", dsrd_hdng, 12'h3FF);
        repeat (5) tick();
        check("move_stp_held", {stp_lft, stp_rght}, 2'b10);
        check("move_strt_gone", strt_mv, 1'b0);
        mv_cmplt = 1'b1;
        tick();
        mv_cmplt = 1'b0;
        check("move_resp", {send_resp, resp}, {1'b1, R_DONE});
        check("move_stp_cleared", {stp_lft, stp_rght}, 2'b00);
        tick();

        // Illegal opcode 3'b101
        cnt0 = strt_cnt;
        send(16'hA000);
        check("ill_c1", send_resp, 1'b0);
        tick();
        check("ill_c2", send_resp, 1'b0);
        tick();
        check("ill_c3_resp", {send_resp, resp}, {1'b1, R_ILL});
        check("ill_no_strt", strt_cnt, cnt0);
        tick();
        check("ill_c4_strobe_gone", send_resp, 1'b0);

        // Completion strobes outside a WAIT state are ignored
        mv_cmplt = 1'b1;
        cal_done = 1'b1;
        tick();
        mv_cmplt = 1'b0;
        cal_done = 1'b0;
        check("stray_cmplt", {send_resp, busy}, 2'b00);
        tick();
        check("stray_cmplt_later", {send_resp, busy}, 2'b00);

        // FLUSH while idle answers on the next cycle
        send(16'hE000);
        check("flush_idle_resp", {send_resp, resp}, {1'b1, R_FLUSH});
        tick();
        check("flush_idle_once", send_resp, 1'b0);

        // Six back-to-back with navigate stalled, then FLUSH during the MOVE
        send(16'h4001);
        send(16'h2123);
        send(16'h0000);
        send(16'hA000);
        send(16'h4002);
        check("burst5_full", cmd_full, 1'b1);
        check("burst5_no_ovfl", ovfl, 1'b0);
        send(16'h2456);
        check("burst6_ovfl", ovfl, 1'b1);
        check("burst6_stp", {stp_lft, stp_rght}, 2'b01);
        cnt0 = strt_cnt;
        send(16'hE000);
        check("flush_busy_empty", cmd_full, 1'b0);
        check("flush_busy_ovfl_clr", ovfl, 1'b0);
        check("flush_busy_no_resp", send_resp, 1'b0);
        mv_cmplt = 1'b1;
        tick();
        mv_cmplt = 1'b0;
        check("flush_move_done_first", {send_resp, resp}, {1'b1, R_DONE});
        tick();
        check("flush_gap", send_resp, 1'b0);
        tick();
        check("flush_resp_after_move", {send_resp, resp}, {1'b1, R_FLUSH});
        repeat (10) tick();
        check("flush_no_more_strt", strt_cnt, cnt0);
        check("flush_idle_after", {busy, send_resp}, 2'b00);

`ifdef NAV_CMD_TMO_EN
        // CAL with no cal_done: 15 WAIT_CAL cycles then 0xE0
        send(16'h0000);
        tick();
        check("tmo_strt_cal", strt_cal, 1'b1);
        repeat (15) tick();
        check("tmo_not_yet", send_resp, 1'b0);
        tick();
        check("tmo_resp", {send_resp, resp}, {1'b1, R_TMO});
        tick();
        // Completion on the timeout edge wins
        send(16'h0000);
        tick();
        repeat (15) tick();
        cal_done = 1'b1;
        tick();
        cal_done = 1'b0;
        check("tmo_cmplt_wins", {send_resp, resp}, {1'b1, R_DONE});
        tick();
`else
        // Without the watchdog the wait is unbounded
        send(16'h0000);
        tick();
        check("nowd_strt_cal", strt_cal, 1'b1);
        repeat (40) tick();
        check("nowd_still_waiting", {busy, send_resp}, 2'b10);
        cal_done = 1'b1;
        tick();
        cal_done = 1'b0;
        check("nowd_resp", {send_resp, resp}, {1'b1, R_DONE});
        tick();
`endif

        // Reset in the middle of WAIT_NAV
        send(16'h2ABC);
        tick();
        check("rst_mid_strt", strt_hdng, 1'b1);
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        check_zero("rst_mid_outputs");
        tick();
        rst_n = 1'b1;
        mv_cmplt = 1'b1;
        tick();
        mv_cmplt = 1'b0;
        repeat (3) tick();
        check("rst_mid_no_resp", {busy, send_resp}, 2'b00);
        check_zero("rst_mid_after");

        // Random bursts: first DEPTH+1 accepted, rest dropped, responses in order
        m_hdng = 12'h000;
        used   = strt_cnt;
        for (int b = 0; b < 25; b++) begin
            len = $urandom_range(1, DEPTH + 3);
            q.delete();
            for (int i = 0; i < len; i++) begin
                w = rand_cmd(i == 0);
                if (i <= DEPTH) q.push_back(w);
                send(w);
            end
            check("rnd_ovfl", ovfl, len > DEPTH + 1);
            check("rnd_full", cmd_full, len >= DEPTH + 1);
            while (q.size() > 0) begin
                w  = q.pop_front();
                op = w[15:13];
                if (op <= 3'd2) begin
                    waited = 0;
                    while (strt_cnt == used && waited < 12) begin
                        tick();
                        waited++;
                    end
                    check("rnd_strt_seen", strt_cnt, used + 1);
                    used = strt_cnt;
                    check("rnd_strt_kind", last_strt, {op == 3'd0, op == 3'd1, op == 3'd2});
                    if (op == 3'd1) m_hdng = w[11:0];
                    check("rnd_heading", last_hdng, m_hdng);
                    if (op == 3'd2) check("rnd_stp", last_stp, w[1:0]);
                    repeat ($urandom_range(1, 5)) tick();
                    if (op == 3'd2) check("rnd_stp_held", {stp_lft, stp_rght}, w[1:0]);
                    check("rnd_busy", busy, 1'b1);
                    if (op == 3'd0) cal_done = 1'b1;
                    else mv_cmplt = 1'b1;
                    tick();
                    cal_done = 1'b0;
                    mv_cmplt = 1'b0;
                    check("rnd_done", {send_resp, resp}, {1'b1, R_DONE});
                    check("rnd_stp_clr", {stp_lft, stp_rght}, 2'b00);
                end else begin
                    waited = 0;
                    while (!send_resp && waited < 12) begin
                        tick();
                        waited++;
                    end
                    check("rnd_ill", {send_resp, resp}, {1'b1, R_ILL});
                    check("rnd_ill_no_strt", strt_cnt, used);
                end
                tick();
            end
            check("rnd_drained", {busy, cmd_full}, 2'b00);
            send(16'hE000);
            check("rnd_flush", {send_resp, resp, ovfl}, {1'b1, R_FLUSH, 1'b0});
            tick();
            check("rnd_no_extra_strt", strt_cnt, used);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/nav_cmd_sched.md
# nav_cmd_sched

Command scheduler sitting between the UART/Bluetooth command receiver and the `navigate` block. It buffers 16-bit motion commands in a small FIFO and issues them to `navigate` (or the inertial calibration logic) one at a time. It waits for completion and returns an 8-bit response for each command. A watchdog aborts the wait if completion never arrives.

## Interface
Parameters:
- DEPTH, 4, command FIFO depth (power of 2, ≥2)
- TMO_W, 26, watchdog counter width; timeout fires when the counter reaches all-ones

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- cmd  in  16  command word: [15:13] opcode, [11:0] heading, [1] stop-left, [0] stop-right
- cmd_vld  in  1  one-cycle strobe, cmd valid
- cmd_full  out  1  FIFO holds DEPTH entries
- ovfl  out  1  sticky: a command was dropped because the FIFO was full
- busy  out  1  a command is executing (state ≠ IDLE)
- strt_cal  out  1  one-cycle pulse to start calibration
- cal_done  in  1  calibration complete
- strt_hdng  out  1  one-cycle pulse to `navigate`
- strt_mv  out  1  one-cycle pulse to `navigate`
- dsrd_hdng  out  12  desired heading to PID, held until the next HDNG command
- stp_lft, stp_rght  out  1 each  held for the whole move, cleared on its completion
- mv_cmplt  in  1  from `navigate`
- send_resp  out  1  one-cycle strobe, resp valid
- resp  out  8  response code, held until the next send_resp

## Operation
- Opcodes:
  - 000 CAL
  - 001 HDNG
  - 010 MOVE
  - 111 FLUSH
  - any other opcode is ILLEGAL
- Response codes:
  - 0xA5 done
  - 0xEE illegal
  - 0xE0 timeout
  - 0xC3 flushed
- Enqueue: on cmd_vld with a non-FLUSH opcode and FIFO not full, the word is written.
  - If the FIFO is full, the word is dropped and ovfl is set.
  - A simultaneous pop frees no space in the same cycle: full means drop.
- FLUSH is never enqueued. At that edge the FIFO is emptied, ovfl is cleared and flush_pend is set.
  - A pop in the same cycle still completes, and the popped command executes.
  - The executing command is not affected.
- State machine (states IDLE, ISSUE, WAIT_NAV, WAIT_CAL, RESP):
  - IDLE, flush_pend set: resp=0xC3, send_resp=1, flush_pend cleared, stay IDLE. This has priority over a pop.
  - IDLE, FIFO not empty: pop into cur_cmd, go to ISSUE.
  - ISSUE with CAL: strt_cal=1, go to WAIT_CAL.
  - ISSUE with HDNG: dsrd_hdng←cur_cmd[11:0], strt_hdng=1, go to WAIT_NAV.
  - ISSUE with MOVE: stp_lft/stp_rght←cur_cmd[1:0], strt_mv=1, go to WAIT_NAV.
  - ISSUE with ILLEGAL: resp=0xEE, go to RESP.
  - WAIT_NAV on mv_cmplt, or WAIT_CAL on cal_done: resp=0xA5, clear stp_lft/stp_rght, go to RESP.
  - RESP: send_resp=1, go to IDLE.
- Watchdog (only with the macro): clears on entry to ISSUE and increments every cycle in WAIT_NAV/WAIT_CAL.
  - At all-ones: resp=0xE0, stop bits cleared, go to RESP.
  - Completion in the same cycle as all-ones wins, giving 0xA5.
- mv_cmplt/cal_done outside the matching WAIT state are ignored.

## Timing
- Reset values:
  - All outputs 0, except cmd_full=0 and FIFO empty.
  - dsrd_hdng=12'h000, resp=8'h00.
  - State IDLE, flush_pend=0.
- cmd_vld at cycle 0 into an idle, empty scheduler:
  - pop at cycle 1 (IDLE)
  - strt_* pulse at cycle 2 (ISSUE)
  - Strobes are registered outputs of the ISSUE/RESP decode, asserted exactly one cycle.
- mv_cmplt at cycle N: send_resp at cycle N+1 (RESP). The next pop is at N+2, and the next strt_* at N+3.
- ILLEGAL: send_resp occurs 3 cycles after cmd_vld.
- FLUSH at cycle F while idle: send_resp with 0xC3 at cycle F+1.
- dsrd_hdng updates in the ISSUE cycle, coincident with strt_hdng. `navigate` samples it from the following cycle.
- The FIFO pointers are DEPTH-modulo with a wrap bit. cmd_full is combinational from the pointers.
- rst_n assertion mid-command returns everything to reset values immediately. No response is sent for the aborted command.

## Configuration
- NAV_CMD_TMO_EN defined: watchdog counter present, and 0xE0 timeouts are generated.
- NAV_CMD_TMO_EN not defined: no counter. WAIT states wait indefinitely for mv_cmplt/cal_done, and TMO_W is unused.

## Structure
- Package nav_cmd_pkg: opcode enum (CAL, HDNG, MOVE, FLUSH), response constants (RESP_DONE, RESP_ILL, RESP_TMO, RESP_FLUSH), state_t enum.
- Sub-module nav_cmd_fifo: parameterized DEPTH×16 synchronous FIFO with wr_en, rd_en, clr, full and empty. clr has priority over wr_en and does not block rd_en.

## Test plan
- HDNG 16'h23FF, then mv_cmplt 20 cycles after strt_hdng → dsrd_hdng=12'h3FF; strt_hdng at cycle 2; resp=0xA5 exactly one cycle after mv_cmplt.
- MOVE 16'h4002 → strt_mv pulse; stp_lft=1 and stp_rght=0 held until mv_cmplt; both 0 in the RESP cycle.
- Five commands back-to-back with DEPTH=4, navigate stalled → first popped; four queued; fifth accepted or dropped per the full rule; ovfl=1 on any drop; responses in FIFO order.
- FLUSH while a MOVE executes with 2 queued → queue empty; 0xC3 sent only after the MOVE's 0xA5; ovfl cleared; no further strt_*.
- Opcode 3'b101 → no strt_* pulse; resp=0xEE at cycle 3.
- With NAV_CMD_TMO_EN and TMO_W=4, CAL with cal_done never asserted → resp=0xE0 after 15 WAIT_CAL cycles; rst_n pulse mid-WAIT_NAV → all outputs 0 and no response.
